// File: rtl/drum_voice_defs.sv
// Shared definitions for the drum-voice playback path: per-channel state
// encodings and the default counter geometry also used by the sample-address block.
package drum_voice_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2
  } voice_state_e;

  localparam int                   DVC_CHANNELS      = 4;
  localparam int                   DVC_WIDTH         = 15;
  localparam logic [DVC_WIDTH-1:0] DVC_DEFAULT_LIMIT = 15'd16481;

endpackage

// File: rtl/drum_voice_counter_if.sv
// Bundle of the per-voice trigger/limit inputs and count/active/done outputs.
// The controller side uses the master modport, the counter block the slave modport.
interface drum_voice_counter_if
  import drum_voice_defs::*;
#(
  parameter int CHANNELS = DVC_CHANNELS,
  parameter int WIDTH    = DVC_WIDTH
);

  logic                      en;
  logic [CHANNELS-1:0]       go;
  logic [CHANNELS-1:0]       loop;
  logic [CHANNELS*WIDTH-1:0] limit;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       active;
  logic [CHANNELS-1:0]       done;

  modport master (
    output en, go, loop, limit,
    input  count, active, done
  );

  modport slave (
    input  en, go, loop, limit,
    output count, active, done
  );

endinterface

// File: rtl/drum_voice_channel.sv
// One drum voice: IDLE/COUNT/PAUSE state machine with a programmable terminal
// count latched on each trigger, optional looping and a one-cycle done pulse.
module drum_voice_channel
  import drum_voice_defs::*;
#(
  parameter int               WIDTH         = DVC_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = DVC_DEFAULT_LIMIT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  input  logic             go_i,
  input  logic             loop_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             active_o,
  output logic             done_o
);

  voice_state_e     state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             loop_q;
  logic             active_q;
  logic             done_q;
  logic [WIDTH-1:0] count_d;

  // The counter never passes the latched limit, so the increment cannot wrap.
  assign count_d = count_q + 1'b1;

  // Voice FSM: reset beats trigger, trigger beats counting; all outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      limit_q  <= DEFAULT_LIMIT;
      loop_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (go_i) begin
      state_q  <= ST_COUNT;
      count_q  <= '0;
      limit_q  <= limit_i;
      loop_q   <= loop_i;
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_COUNT: begin
          done_q <= 1'b0;
          if (en_i) begin
            if (count_q < limit_q) begin
              count_q <= count_d;
            end else if (loop_q) begin
              count_q <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_PAUSE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        ST_IDLE, ST_PAUSE: begin
          done_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign count_o  = count_q;
  assign active_o = active_q;
  assign done_o   = done_q;

endmodule

// File: rtl/drum_voice_counter.sv
// Multi-voice period counter: CHANNELS independent drum_voice_channel
// instances sharing one count tick, with packed per-channel limit/count buses.
module drum_voice_counter
  import drum_voice_defs::*;
#(
  parameter int               CHANNELS      = DVC_CHANNELS,
  parameter int               WIDTH         = DVC_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = DVC_DEFAULT_LIMIT
) (
  input  logic                 clk,
  input  logic                 resetn,
  drum_voice_counter_if.slave  bus
);

  logic [CHANNELS*WIDTH-1:0] count_w;
  logic [CHANNELS-1:0]       active_w;
  logic [CHANNELS-1:0]       done_w;

  // One voice per channel; channel i owns bits [i*WIDTH +: WIDTH] of limit/count.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    drum_voice_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .en_i     (bus.en),
      .go_i     (bus.go[i]),
      .loop_i   (bus.loop[i]),
      .limit_i  (bus.limit[i*WIDTH +: WIDTH]),
      .count_o  (count_w[i*WIDTH +: WIDTH]),
      .active_o (active_w[i]),
      .done_o   (done_w[i])
    );
  end

  assign bus.count  = count_w;
  assign bus.active = active_w;
  assign bus.done   = done_w;

endmodule

// File: tb/tb_drum_voice_counter.sv
// Bench for drum_voice_counter: directed stimulus, a tick-counting reference
// model compared every cycle, and hand-computed literal expectations.
module tb_drum_voice_counter;
  import drum_voice_defs::*;

  localparam int CH = 4;
  localparam int W  = 15;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  drum_voice_counter_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  drum_voice_counter #(
    .CHANNELS      (CH),
    .WIDTH         (W),
    .DEFAULT_LIMIT (15'd16481)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: state 0 = never triggered, 1 = running, 2 = finished one-shot.
  // m_n counts en ticks since the last trigger.
  int m_st [CH];
  int m_n  [CH];
  int m_L  [CH];
  bit m_loop [CH];
  bit m_done [CH];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int exp_count(input int i);
    if (m_st[i] == 1) return m_loop[i] ? (m_n[i] % (m_L[i] + 1)) : m_n[i];
    if (m_st[i] == 2) return m_L[i];
    return 0;
  endfunction

  function automatic int cnt(input int ch);
    return int'(bus.count[ch*W +: W]);
  endfunction

  task automatic set_ch(input int ch, input int lim, input bit lp);
    bus.limit[ch*W +: W] = lim[W-1:0];
    bus.loop[ch]         = lp;
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_st[i] = 0; m_n[i] = 0; m_L[i] = 16481; m_loop[i] = 1'b0; m_done[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (!resetn) begin
        m_st[i] = 0; m_n[i] = 0; m_L[i] = 16481; m_loop[i] = 1'b0; m_done[i] = 1'b0;
      end else if (bus.go[i]) begin
        m_st[i] = 1; m_n[i] = 0; m_L[i] = int'(bus.limit[i*W +: W]);
        m_loop[i] = bus.loop[i]; m_done[i] = 1'b0;
      end else if (m_st[i] == 1 && bus.en) begin
        m_n[i]++;
        if (m_loop[i]) begin
          m_done[i] = ((m_n[i] % (m_L[i] + 1)) == 0);
        end else if (m_n[i] == m_L[i] + 1) begin
          m_st[i] = 2; m_done[i] = 1'b1;
        end else begin
          m_done[i] = 1'b0;
        end
      end else begin
        m_done[i] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("model_ch%0d_count", i), cnt(i), exp_count(i));
        chk($sformatf("model_ch%0d_active", i), bus.active[i], (m_st[i] == 1) ? 1 : 0);
        chk($sformatf("model_ch%0d_done", i), bus.done[i], m_done[i]);
      end
    end
  end

  initial begin
    int pulses;
    int first [CH];
    int pcount [CH];

    resetn    = 1'b0;
    bus.go    = '1;
    bus.en    = 1'b1;
    bus.loop  = '0;
    bus.limit = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_active", bus.active, 0);
    chk("rst_done", bus.done, 0);
    resetn = 1'b1;
    bus.go = '0;

    // One-shot, limit 3 on channel 0.
    set_ch(0, 3, 1'b0);
    bus.go = 4'b0001;
    @(negedge clk);
    bus.go = '0;
    chk("os_start_count", cnt(0), 0);
    chk("os_start_active", bus.active[0], 1);
    repeat (3) @(negedge clk);
    chk("os_count3", cnt(0), 3);
    chk("os_no_early_done", bus.done[0], 0);
    @(negedge clk);
    chk("os_done", bus.done[0], 1);
    chk("os_inactive", bus.active[0], 0);
    repeat (20) @(negedge clk);
    chk("os_hold", cnt(0), 3);

    // Loop, limit 2 on channel 1, en toggling.
    set_ch(1, 2, 1'b1);
    bus.go = 4'b0010;
    @(negedge clk);
    bus.go = '0;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      bus.en = (j % 2 == 0);
      @(negedge clk);
      if (bus.done[1]) pulses++;
    end
    chk("loop_pulses", pulses, 2);
    chk("loop_count", cnt(1), 0);
    bus.en = 1'b1;

    // Retrigger channel 2 mid-count with a new limit.
    set_ch(2, 5, 1'b0);
    bus.go = 4'b0100;
    @(negedge clk);
    bus.go = '0;
    repeat (4) @(negedge clk);
    chk("rt_at4", cnt(2), 4);
    set_ch(2, 1, 1'b0);
    bus.go = 4'b0100;
    @(negedge clk);
    bus.go = '0;
    chk("rt_zero", cnt(2), 0);
    chk("rt_nodone", bus.done[2], 0);
    repeat (2) @(negedge clk);
    chk("rt_done", bus.done[2], 1);
    chk("rt_count", cnt(2), 1);
    chk("rt_inactive", bus.active[2], 0);

    // Trigger on the terminal edge: go wins, no done.
    set_ch(2, 2, 1'b1);
    bus.go = 4'b0100;
    @(negedge clk);
    bus.go = '0;
    repeat (2) @(negedge clk);
    chk("col_pre", cnt(2), 2);
    bus.go = 4'b0100;
    @(negedge clk);
    bus.go = '0;
    chk("col_count", cnt(2), 0);
    chk("col_nodone", bus.done[2], 0);
    chk("col_active", bus.active[2], 1);

    // All four channels on one edge, limits 0, 1, 7, 16481, one-shot.
    set_ch(0, 0, 1'b0);
    set_ch(1, 1, 1'b0);
    set_ch(2, 7, 1'b0);
    set_ch(3, 16481, 1'b0);
    bus.go = 4'b1111;
    @(negedge clk);
    bus.go = '0;
    for (int i = 0; i < CH; i++) begin
      first[i] = -1; pcount[i] = 0;
    end
    for (int j = 1; j <= 16490; j++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (bus.done[i]) begin
          pcount[i]++;
          if (first[i] < 0) first[i] = j;
        end
      end
    end
    chk("ind_first_ch0", first[0], 1);
    chk("ind_first_ch1", first[1], 2);
    chk("ind_first_ch2", first[2], 8);
    chk("ind_first_ch3", first[3], 16482);
    for (int i = 0; i < CH; i++) chk($sformatf("ind_pulses_ch%0d", i), pcount[i], 1);
    chk("ind_hold_ch3", cnt(3), 16481);

    // Loop with limit 0: done on every tick.
    set_ch(0, 0, 1'b1);
    bus.go = 4'b0001;
    @(negedge clk);
    bus.go = '0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done[0]) pulses++;
    end
    chk("l0_pulses", pulses, 5);

    // Reset in the middle of a looping count.
    set_ch(1, 200, 1'b1);
    bus.go = 4'b0010;
    @(negedge clk);
    bus.go = '0;
    repeat (100) @(negedge clk);
    chk("mr_pre", cnt(1), 100);
    resetn = 1'b0;
    @(negedge clk);
    chk("mr_count", bus.count, 0);
    chk("mr_active", bus.active, 0);
    chk("mr_done", bus.done, 0);
    resetn = 1'b1;
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_idle_active", bus.active, 0);
    chk("mr_idle_count", bus.count, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_voice_counter.md
# drum_voice_counter

Multi-channel, parametrised period counter for the drum-voice playback path. It generalises the single-channel snare counter to `CHANNELS` independent voices. Each voice has a per-trigger programmable terminal count, one-shot or loop mode, a done pulse and an explicit idle state. The sample-address logic and the audio mixer sit downstream and consume each channel's `count`, `active` and `done`.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent voice channels (1–16).
- `WIDTH`, 15: counter width per channel.
- `DEFAULT_LIMIT`, 15'd16481: terminal count loaded at reset.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `resetn`, in, 1: synchronous reset, active-low; sampled on `clk` rising edge.
- `en`, in, 1: global count tick shared by all channels; counting advances only when high.
- `go`, in, `CHANNELS`: per-channel trigger; restarts that channel.
- `loop`, in, `CHANNELS`: per-channel mode, sampled with `go`; 1 = loop, 0 = one-shot.
- `limit`, in, `CHANNELS*WIDTH`: per-channel terminal count, sampled with `go`; channel i occupies bits [i*WIDTH +: WIDTH].
- `count`, out, `CHANNELS*WIDTH`: per-channel current count, same packing as `limit`.
- `active`, out, `CHANNELS`: channel is in COUNT.
- `done`, out, `CHANNELS`: one-cycle pulse when a channel completes a period.

## Operation
- Each channel is an FSM with three states:
  - IDLE: the reset state; never triggered.
  - COUNT
  - PAUSE: one-shot finished; holds the final count.
- Per channel, each edge, in priority order:
  1. `resetn`=0: state=IDLE, `count`=0, latched limit=`DEFAULT_LIMIT`, latched loop=0, `done`=0.
  2. `go[i]`=1 (in any state, including mid-count): state=COUNT, `count`=0, latch `limit[i]` and `loop[i]`, `done`=0.
  3. COUNT with `en`=1:
     - `count` < latched limit: `count`+1.
     - `count` == latched limit, loop=1: `count`=0, `done`=1, stay in COUNT.
     - `count` == latched limit, loop=0: `count` holds, `done`=1, go to PAUSE.
  4. COUNT with `en`=0: hold; `done`=0.
  5. IDLE or PAUSE without `go`: hold `count`; `done`=0.
- `active[i]` is 1 exactly when the state is COUNT.
- Period is latched limit + 1 `en` ticks. Count sequence is 0..L, then `done`.
- Latched limit = 0: every `en` tick while in COUNT raises `done`.
- Changing `limit`/`loop` inputs without `go` has no effect on a running channel.
- Channels are fully independent. Simultaneous `go` on several channels is legal and each behaves as if alone.
- Arithmetic is unsigned, `WIDTH` bits. The counter never passes the latched limit, so no wrap-around is reachable.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `go` sampled at edge k: `count`=0 and `active`=1 visible after edge k. The first increment is at the next edge with `en`=1.
- `done` is high for exactly the one cycle after the terminal edge. In one-shot mode it coincides with `active` falling.
- `go` on the same edge as the terminal condition: `go` wins, `count`=0, no `done`.
- Reset at any point in operation overrides `go` and `en`. All outputs read 0 after the reset edge.

## Structure
- Shared package/header `drum_voice_defs`:
  - State encodings `ST_IDLE`=2'd0, `ST_COUNT`=2'd1, `ST_PAUSE`=2'd2.
  - Default `WIDTH`/`DEFAULT_LIMIT` constants, reused by the sample-address block.
- One sub-module, `drum_voice_channel`: scalar ports, holds one FSM, counter, limit/loop latches and `done` register.
- The top generates `CHANNELS` instances and handles packing/unpacking of `limit` and `count`.

## Test plan
- Reset: `resetn`=0 for 2 cycles with `go`=all-1 and `en`=1 → `count`=0, `active`=0, `done`=0 on every channel.
- One-shot: ch0 `go` with `limit`=3, `loop`=0, `en`=1 continuously → `count` 0,1,2,3; `done` pulses once on the 4th tick; `active` drops; `count` holds at 3 for 20 more cycles.
- Loop with gated `en`: ch1 `limit`=2, `loop`=1, `en` toggling 1/0 → `count` 0,1,2,0,1,2 advancing only on `en` cycles; `done` on each wrap, never on `en`=0 cycles.
- Retrigger and collision: ch2 `limit`=5, re-`go` at `count`=4 with `limit`=1 → `count`=0 next cycle and new period of 2 ticks. Separately, `go` on the terminal edge → `count`=0 and no `done`.
- Independence and edge cases: all 4 channels triggered on the same edge with limits 0,1,7,16481, `en`=1 →
  - ch0 gives `done` every tick until PAUSE.
  - ch3 gives `done` after 16482 ticks.
  - No cross-channel interaction.
- Mid-operation reset: assert `resetn`=0 during `count`=100 on a looping channel → all outputs 0 next edge; channel stays IDLE until its next `go`.
